decode_stage: RTL

Pipelined, parametrised instruction-decode stage for the RV32I core. It replaces the single-cycle decode path with a registered ID/EX boundary and valid/ready handshakes on both sides. It also adds load-use hazard stalling, branch flush, and write-back-to-read bypass. It sits between the fetch stage (IF/ID) and the execute stage, and owns the architectural register file.

---
 rtl/core_pkg.sv | 71 +++++++
 rtl/decode_stage_if.sv | 50 +++++
 rtl/regfile_bypass.sv | 34 +++
 rtl/decode_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I decode encodings and ID/EX control bundle
package core_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_src_e;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_SLL   = 5'd2,
      ALU_SLT   = 5'd3,
      ALU_SLTU  = 5'd4,
      ALU_XOR   = 5'd5,
      ALU_SRL   = 5'd6,
      ALU_SRA   = 5'd7,
      ALU_OR    = 5'd8,
      ALU_AND   = 5'd9,
      ALU_PASSB = 5'd10
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2
   } result_src_e;

   typedef struct packed {
      alu_ctrl_e   alu_ctrl;
      logic        alu_src;
      result_src_e result_src;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic [2:0]  funct3;
      logic        illegal;
   } id_ex_ctrl_t;

   // SUB only exists for register-register; SRA/SRL split on bit 30 for both forms
   function automatic alu_ctrl_e alu_from_funct(input logic [2:0] f3, input logic b30,
                                                input logic is_r);
      case (f3)
         3'b000:  alu_from_funct = (is_r && b30) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_from_funct = ALU_SLL;
         3'b010:  alu_from_funct = ALU_SLT;
         3'b011:  alu_from_funct = ALU_SLTU;
         3'b100:  alu_from_funct = ALU_XOR;
         3'b101:  alu_from_funct = b30 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_from_funct = ALU_OR;
         default: alu_from_funct = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, write-back and execute side signals of the decode stage
interface decode_stage_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            wb_we;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rd1;
   logic [XLEN-1:0] ex_rd2;
   logic [XLEN-1:0] ex_imm;
   logic [AW-1:0]   ex_rs1;
   logic [AW-1:0]   ex_rs2;
   logic [AW-1:0]   ex_rd;
   logic [4:0]      ex_alu_ctrl;
   logic            ex_alu_src;
   logic [1:0]      ex_result_src;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_reg_write;
   logic            ex_branch;
   logic            ex_jump;
   logic            ex_jalr;
   logic [2:0]      ex_funct3;
   logic            ex_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
      output in_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_ctrl, ex_alu_src, ex_result_src, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_funct3, ex_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
      input  in_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_ctrl, ex_alu_src, ex_result_src, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_funct3, ex_illegal
   );
endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - architectural register file, two async reads, one sync write
// A same-cycle write-back is forwarded to either read port; x0 is hard zero.
module regfile_bypass #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_we,
   input  logic [AW-1:0]   i_wa,
   input  logic [XLEN-1:0] i_wd,
   input  logic [AW-1:0]   i_ra1,
   input  logic [AW-1:0]   i_ra2,
   output logic [XLEN-1:0] o_rd1,
   output logic [XLEN-1:0] o_rd2
);
   logic [XLEN-1:0] r_mem [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_wa != '0)) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == '0)                ? '0   :
                  (i_we && (i_wa == i_ra1))    ? i_wd : r_mem[i_ra1];
   assign o_rd2 = (i_ra2 == '0)                ? '0   :
                  (i_we && (i_wa == i_ra2))    ? i_wd : r_mem[i_ra2];
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with registered ID/EX boundary
// Decodes the IF/ID beat, stalls on load-use hazards, flushes on taken branches.
module decode_stage
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [31:0]     w_instr;
   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [AW-1:0]   w_rs1_f, w_rs2_f, w_rd_f;
   logic [AW-1:0]   w_rs1, w_rs2, w_rd;
   logic            w_use_rs1, w_use_rs2;
   imm_src_e        w_imm_src;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm, w_rd1, w_rd2;
   id_ex_ctrl_t     w_ctrl;
   logic            w_hazard, w_can_adv, w_accept, w_clear;

   logic            r_valid;
   id_ex_ctrl_t     r_ctrl;
   logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
   logic [AW-1:0]   r_rs1, r_rs2, r_rd;

   assign w_instr  = bus.in_instr;
   assign w_opcode = w_instr[6:0];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1_f  = w_instr[15 +: AW];
   assign w_rs2_f  = w_instr[20 +: AW];
   assign w_rd_f   = w_instr[7 +: AW];

   always_comb begin
      w_ctrl        = '0;
      w_ctrl.funct3 = w_funct3;
      w_imm_src     = IMM_I;
      w_use_rs1     = 1'b0;
      w_use_rs2     = 1'b0;
      case (w_opcode)
         OP_R: begin
            w_ctrl.alu_ctrl  = alu_from_funct(w_funct3, w_instr[30], 1'b1);
            w_ctrl.reg_write = 1'b1;
            w_use_rs1        = 1'b1;
            w_use_rs2        = 1'b1;
         end
         OP_I: begin
            w_ctrl.alu_ctrl  = alu_from_funct(w_funct3, w_instr[30], 1'b0);
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_use_rs1        = 1'b1;
         end
         OP_LOAD: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = RES_MEM;
            w_ctrl.mem_read   = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_use_rs1         = 1'b1;
         end
         OP_STORE: begin
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.mem_write = 1'b1;
            w_imm_src        = IMM_S;
            w_use_rs1        = 1'b1;
            w_use_rs2        = 1'b1;
         end
         OP_BRANCH: begin
            w_ctrl.alu_ctrl = ALU_SUB;
            w_ctrl.branch   = 1'b1;
            w_imm_src       = IMM_B;
            w_use_rs1       = 1'b1;
            w_use_rs2       = 1'b1;
         end
         OP_JAL: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = RES_PC4;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.jump       = 1'b1;
            w_imm_src         = IMM_J;
         end
         OP_JALR: begin
            w_ctrl.alu_src    = 1'b1;
            w_ctrl.result_src = RES_PC4;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.jump       = 1'b1;
            w_ctrl.jalr       = 1'b1;
            w_use_rs1         = 1'b1;
         end
         OP_LUI: begin
            w_ctrl.alu_ctrl  = ALU_PASSB;
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_imm_src        = IMM_U;
         end
         OP_AUIPC: begin
            w_ctrl.alu_src   = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_imm_src        = IMM_U;
         end
         default: w_ctrl.illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (w_imm_src)
         IMM_S:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         IMM_B:   w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                             w_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {w_instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                             w_instr[30:21], 1'b0};
         default: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      endcase
   end
   assign w_imm = XLEN'($signed(w_imm32));

   // Unused fields are reported as x0 so EX forwarding never matches on immediate bits
   assign w_rs1 = w_use_rs1        ? w_rs1_f : '0;
   assign w_rs2 = w_use_rs2        ? w_rs2_f : '0;
   assign w_rd  = w_ctrl.reg_write ? w_rd_f  : '0;

   regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk   (clk),
      .reset (reset),
      .i_we  (bus.wb_we),
      .i_wa  (bus.wb_rd),
      .i_wd  (bus.wb_data),
      .i_ra1 (w_rs1),
      .i_ra2 (w_rs2),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2)
   );

   assign w_hazard  = r_valid && r_ctrl.mem_read && (r_rd != '0) &&
                      ((w_use_rs1 && (w_rs1_f == r_rd)) || (w_use_rs2 && (w_rs2_f == r_rd)));
   assign w_can_adv = !r_valid || bus.ex_ready;
   assign w_accept  = bus.in_valid && !bus.flush && !w_hazard && w_can_adv;
   assign w_clear   = bus.flush || (w_can_adv && !w_accept);
   // During a flush fetch must see ready so its killed beat is consumed
   assign bus.in_ready = bus.flush || (!w_hazard && w_can_adv);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_pc    <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
      end else if (w_clear) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_pc    <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_imm   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_ctrl  <= w_ctrl;
         r_pc    <= bus.in_pc;
         r_rd1   <= w_rd1;
         r_rd2   <= w_rd2;
         r_imm   <= w_imm;
         r_rs1   <= w_rs1;
         r_rs2   <= w_rs2;
         r_rd    <= w_rd;
      end
   end

   assign bus.ex_valid      = r_valid;
   assign bus.ex_pc         = r_pc;
   assign bus.ex_rd1        = r_rd1;
   assign bus.ex_rd2        = r_rd2;
   assign bus.ex_imm        = r_imm;
   assign bus.ex_rs1        = r_rs1;
   assign bus.ex_rs2        = r_rs2;
   assign bus.ex_rd         = r_rd;
   assign bus.ex_alu_ctrl   = r_ctrl.alu_ctrl;
   assign bus.ex_alu_src    = r_ctrl.alu_src;
   assign bus.ex_result_src = r_ctrl.result_src;
   assign bus.ex_mem_read   = r_ctrl.mem_read;
   assign bus.ex_mem_write  = r_ctrl.mem_write;
   assign bus.ex_reg_write  = r_ctrl.reg_write;
   assign bus.ex_branch     = r_ctrl.branch;
   assign bus.ex_jump       = r_ctrl.jump;
   assign bus.ex_jalr       = r_ctrl.jalr;
   assign bus.ex_funct3     = r_ctrl.funct3;
   assign bus.ex_illegal    = r_ctrl.illegal;
endmodule
